// File: rtl/mac_operand_loader.sv
// Operand loader: assembles one B-vector plus LANES A-rows from a valid/ready stream and issues the tile.
// Define LOADER_DOUBLE_BUF_EN to add a shadow bank that fills while the active tile is still in use.
module mac_operand_loader #(
  parameter int LANES  = 16,
  parameter int WORD_W = 264,
  parameter int CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_cfg,
  input  logic                    tile_done,
  output logic [LANES*WORD_W-1:0] a_vec,
  output logic [WORD_W-1:0]       b_vec,
  output logic                    is_int8_mode,
  output logic                    is_int4_mode,
  output logic                    is_vsq,
  output logic                    valid_mac,
  output logic                    busy,
  output logic                    cfg_err,
  output logic [15:0]             tile_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT} state_t;

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(LANES);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [LANES*WORD_W-1:0]   a_q, a_d;
  logic [WORD_W-1:0]         b_q, b_d;
  logic [2:0]                mode_q, mode_d;
  logic                      err_q, err_d;
  logic                      vmac_q, vmac_d;
  logic                      busy_q, busy_d;
  logic                      in_ready_q, in_ready_d;
  logic [15:0]               tcnt_q, tcnt_d;

  logic                      accept;
  logic                      both_fmt;
  logic [2:0]                cfg_res;
  logic [CNT_W-1:0]          row;

  assign accept   = in_valid && in_ready_q;
  assign both_fmt = in_cfg[0] && in_cfg[1];
  // {vsq,int4,int8}; a conflicting int8+int4 request resolves to int8
  assign cfg_res  = {in_cfg[2], in_cfg[1] && !in_cfg[0], in_cfg[0]};
  assign row      = cnt_q - 1'b1;

`ifdef LOADER_DOUBLE_BUF_EN
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LANES + 1);

  logic [LANES*WORD_W-1:0] sh_a_q, sh_a_d;
  logic [WORD_W-1:0]       sh_b_q, sh_b_d;
  logic [2:0]              sh_mode_q, sh_mode_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    err_d      = err_q;
    busy_d     = busy_q;
    tcnt_d     = tcnt_q;
    vmac_d     = 1'b0;
    in_ready_d = 1'b0;
`ifdef LOADER_DOUBLE_BUF_EN
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    sh_mode_d = sh_mode_q;
    // All beats land in the shadow bank; the active bank only changes on a swap
    if (accept) begin
      if (cnt_q == '0) begin
        sh_b_d    = in_data;
        sh_mode_d = cfg_res;
        err_d     = err_q | both_fmt;
      end else begin
        sh_a_d[int'(row)*WORD_W +: WORD_W] = in_data;
      end
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE, FILL: begin
        if (cnt_d == FULL)       state_d = ISSUE;
        else if (cnt_d != '0)    state_d = FILL;
      end
      ISSUE:                     state_d = WAIT;
      default: begin
        if (tile_done) state_d = (cnt_d == FULL) ? ISSUE : ((cnt_d == '0) ? IDLE : FILL);
      end
    endcase
    if (state_d == ISSUE) begin
      a_d    = sh_a_d;
      b_d    = sh_b_d;
      mode_d = sh_mode_d;
      cnt_d  = '0;
    end
    in_ready_d = (state_d != ISSUE) && (cnt_d != FULL);
`else
    if (accept) begin
      if (cnt_q == '0) begin
        b_d    = in_data;
        mode_d = cfg_res;
        err_d  = err_q | both_fmt;
      end else begin
        a_d[int'(row)*WORD_W +: WORD_W] = in_data;
      end
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE, FILL: begin
        if (accept && cnt_q == LAST_ROW) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end else if (accept) begin
          state_d = FILL;
        end
      end
      ISSUE:                     state_d = WAIT;
      default: if (tile_done)    state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == FILL);
`endif
    // Leaving WAIT clears busy; entering ISSUE (possibly straight from WAIT) sets it again
    if (state_q == WAIT && state_d != WAIT) busy_d = 1'b0;
    if (state_d == ISSUE) begin
      vmac_d = 1'b1;
      busy_d = 1'b1;
      tcnt_d = tcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      err_q      <= 1'b0;
      vmac_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      tcnt_q     <= '0;
`ifdef LOADER_DOUBLE_BUF_EN
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      sh_mode_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      vmac_q     <= vmac_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      tcnt_q     <= tcnt_d;
`ifdef LOADER_DOUBLE_BUF_EN
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      sh_mode_q  <= sh_mode_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign a_vec        = a_q;
  assign b_vec        = b_q;
  assign is_int8_mode = mode_q[0];
  assign is_int4_mode = mode_q[1];
  assign is_vsq       = mode_q[2];
  assign valid_mac    = vmac_q;
  assign busy         = busy_q;
  assign cfg_err      = err_q;
  assign tile_cnt     = tcnt_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
// Self-checking bench for mac_operand_loader: tile-level reference model plus directed and table-driven sequences.
module tb_mac_operand_loader;
  localparam int LANES = 16;
  localparam int W     = 264;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic [2:0] in_cfg = '0;
  logic tile_done = 1'b0;
  logic [LANES*W-1:0] a_vec;
  logic [W-1:0] b_vec;
  logic is_int8_mode, is_int4_mode, is_vsq, valid_mac, busy, cfg_err;
  logic [15:0] tile_cnt;

  always #5 clk = ~clk;

  mac_operand_loader #(.LANES(LANES), .WORD_W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_cfg(in_cfg), .tile_done(tile_done), .a_vec(a_vec), .b_vec(b_vec),
    .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode), .is_vsq(is_vsq),
    .valid_mac(valid_mac), .busy(busy), .cfg_err(cfg_err), .tile_cnt(tile_cnt));

  typedef struct {
    logic [W-1:0]       b;
    logic [LANES*W-1:0] a;
    logic [2:0]         cfg;
  } tile_t;

  typedef struct {
    logic [2:0] cfg;
    logic       i8, i4, vsq, err;
  } cfg_vec_t;

  tile_t pend[$];
  tile_t bld, cur;
  int bidx = 0, nvec = 0, nerr = 0, dut_pulses = 0;
  bit busy_m = 0, err_m = 0, issue_prev = 0, last_acc = 0, rdy_seen = 0;
  logic [15:0] tcnt_m = '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic [LANES*W-1:0] act, input logic [LANES*W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      for (int k = 0; k < LANES; k++)
        if (act[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s row %0d: got %h want %h", nm, k, act[k*W +: W], exp[k*W +: W]);
          break;
        end
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w = '0;
    repeat (9) w = (w << 32) | W'($urandom);
    return w;
  endfunction

  // One clock: advance, then update the tile-level model and compare every observable
  task automatic tick();
    bit acc, dn, issue_now;
    logic [W-1:0] d;
    logic [2:0] c;
    acc = in_valid && rdy_seen;
    dn  = tile_done;
    d   = in_data;
    c   = in_cfg;
    @(posedge clk); #1;
    last_acc = acc;
    if (acc) begin
      if (bidx == 0) begin
        bld.b = d; bld.cfg = c; bld.a = '0;
        if (c[0] && c[1]) err_m = 1;
      end else begin
        bld.a[(bidx-1)*W +: W] = d;
      end
      bidx++;
      if (bidx == LANES + 1) begin
        pend.push_back(bld);
        bidx = 0;
      end
    end
    if (dn && busy_m && !issue_prev) busy_m = 0;
    issue_now = (pend.size() > 0) && !busy_m;
    if (valid_mac) dut_pulses++;
    chk("valid_mac", W'(valid_mac), W'(issue_now));
    if (issue_now) begin
      cur = pend.pop_front();
      busy_m = 1;
      tcnt_m = tcnt_m + 16'd1;
      chk_a("issue a_vec", a_vec, cur.a);
      chk("issue b_vec", b_vec, cur.b);
      chk("issue int8", W'(is_int8_mode), W'(cur.cfg[0]));
      chk("issue int4", W'(is_int4_mode), W'(cur.cfg[1] && !cur.cfg[0]));
      chk("issue vsq", W'(is_vsq), W'(cur.cfg[2]));
      chk("issue cfg_err", W'(cfg_err), W'(err_m));
      chk("issue tile_cnt", W'(tile_cnt), W'(tcnt_m));
    end else if (busy_m) begin
      chk_a("hold a_vec", a_vec, cur.a);
      chk("hold b_vec", b_vec, cur.b);
    end
    chk("busy", W'(busy), W'(busy_m));
`ifdef LOADER_DOUBLE_BUF_EN
    chk("in_ready", W'(in_ready), W'(!issue_now && pend.size() == 0));
`else
    chk("in_ready", W'(in_ready), W'(!busy_m));
`endif
    issue_prev = issue_now;
    rdy_seen   = in_ready;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; tile_done = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_a("rst a_vec", a_vec, '0);
    chk("rst b_vec", b_vec, '0);
    chk("rst int8", W'(is_int8_mode), '0);
    chk("rst int4", W'(is_int4_mode), '0);
    chk("rst vsq", W'(is_vsq), '0);
    chk("rst valid_mac", W'(valid_mac), '0);
    chk("rst busy", W'(busy), '0);
    chk("rst cfg_err", W'(cfg_err), '0);
    chk("rst tile_cnt", W'(tile_cnt), '0);
    chk("rst in_ready", W'(in_ready), '0);
    pend.delete();
    bidx = 0; busy_m = 0; err_m = 0; tcnt_m = '0; issue_prev = 0;
    rst = 0;
    @(posedge clk); #1;
    rdy_seen = in_ready;
  endtask

  task automatic drive_beat(input logic [W-1:0] d, input logic [2:0] c, input int bub);
    int g = 0;
    repeat ($urandom_range(0, bub)) begin
      in_valid = 0;
      tick();
    end
    in_valid = 1; in_data = d; in_cfg = c;
    do begin
      tick();
      g++;
    end while (!last_acc && g < 100);
    if (!last_acc) begin
      nvec++; nerr++;
      $display("FAIL beat timeout: in_ready %0b, required a handshake within 100 cycles", in_ready);
    end
  endtask

  // Beats lo..hi-1 of a tile; beat 0 carries c0, later beats carry cl
  task automatic send_tile(input logic [2:0] c0, input logic [2:0] cl, input int bub,
                           input bit pat, input int lo, input int hi);
    logic [7:0] b8;
    logic [W-1:0] d;
    for (int i = lo; i < hi; i++) begin
      b8 = 8'(i);
      d  = pat ? {33{b8}} : rand_word();
      drive_beat(d, (i == 0) ? c0 : cl, bub);
    end
    in_valid = 0;
  endtask

  task automatic release_tile(input int maxd);
    int g = 0;
    repeat ($urandom_range(1, maxd)) tick();
    tile_done = 1;
    while ((busy_m || pend.size() > 0) && g < 50) begin
      tick();
      g++;
    end
    tile_done = 0;
    if (g >= 50) begin
      nvec++; nerr++;
      $display("FAIL release timeout: busy %0b, required 0 within 50 cycles", busy);
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_vec_t tbl[8];
    int p0;
    logic [7:0] v10, v01;
    tbl[0] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{3'b110, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{3'b011, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{3'b111, 1'b1, 1'b0, 1'b1, 1'b1};
    v10 = 8'h10;
    v01 = 8'h01;

    do_reset();

    // Reset in the middle of a fill, then a fresh tile
    send_tile(3'b000, 3'b000, 0, 0, 0, 8);
    do_reset();
    send_tile(3'b000, 3'b000, 0, 0, 0, LANES + 1);
    chk("t1 valid_mac", W'(valid_mac), W'(1'b1));
    chk("t1 tile_cnt", W'(tile_cnt), W'(16'd1));
    release_tile(3);

    // Basic patterned tile, in_valid held high
    send_tile(3'b000, 3'b000, 0, 1, 0, LANES + 1);
    chk("t2 valid_mac", W'(valid_mac), W'(1'b1));
    chk("t2 b_vec", b_vec, '0);
    chk("t2 row0", a_vec[0 +: W], {33{v01}});
    chk("t2 row15", a_vec[15*W +: W], {33{v10}});
`ifndef LOADER_DOUBLE_BUF_EN
    repeat (3) begin
      tick();
      chk("t2 in_ready", W'(in_ready), '0);
    end
`endif
    release_tile(2);

    // Same pattern with random bubbles
    p0 = dut_pulses;
    send_tile(3'b000, 3'b000, 3, 1, 0, LANES + 1);
    chk("t3 b_vec", b_vec, '0);
    chk("t3 row15", a_vec[15*W +: W], {33{v10}});
    release_tile(4);
    chk("t3 pulses", W'(dut_pulses - p0), W'(1));

    // Config table; later beats carry the inverted cfg, which must be ignored
    foreach (tbl[i]) begin
      send_tile(tbl[i].cfg, ~tbl[i].cfg, 1, 0, 0, LANES + 1);
      chk("cfg int8", W'(is_int8_mode), W'(tbl[i].i8));
      chk("cfg int4", W'(is_int4_mode), W'(tbl[i].i4));
      chk("cfg vsq", W'(is_vsq), W'(tbl[i].vsq));
      chk("cfg err", W'(cfg_err), W'(tbl[i].err));
      release_tile(2);
    end
    do_reset();

    // tile_done in IDLE and in the ISSUE cycle is ignored; long hold in WAIT
    tile_done = 1; tick(); tick(); tile_done = 0;
    chk("t5 idle tile_cnt", W'(tile_cnt), '0);
    chk("t5 idle busy", W'(busy), '0);
    send_tile(3'b001, 3'b000, 1, 0, 0, LANES + 1);
    tile_done = 1; tick(); tile_done = 0;
    chk("t5 issue-cycle done busy", W'(busy), W'(1'b1));
    repeat (20) tick();
    tile_done = 1; tick(); tile_done = 0;
    chk("t5 ack busy", W'(busy), '0);
    chk("t5 ack in_ready", W'(in_ready), W'(1'b1));
    tick();

`ifdef LOADER_DOUBLE_BUF_EN
    // Back-to-back tiles: second fills in the shadow and issues right after tile_done
    do_reset();
    send_tile(3'b000, 3'b000, 0, 0, 0, LANES + 1);
    send_tile(3'b100, 3'b000, 0, 0, 0, LANES + 1);
    repeat (5) tick();
    chk("t6 held valid_mac", W'(valid_mac), '0);
    tile_done = 1; tick(); tile_done = 0;
    chk("t6 valid_mac", W'(valid_mac), W'(1'b1));
    chk("t6 tile_cnt", W'(tile_cnt), W'(16'd2));
    release_tile(3);
    // Partial shadow at tile_done: issue when the remaining beats arrive
    send_tile(3'b000, 3'b000, 0, 0, 0, LANES + 1);
    send_tile(3'b010, 3'b000, 1, 0, 0, 8);
    tile_done = 1; tick(); tile_done = 0;
    send_tile(3'b010, 3'b000, 1, 0, 8, LANES + 1);
    chk("t6 partial valid_mac", W'(valid_mac), W'(1'b1));
    release_tile(3);
`endif

    // Randomized tiles
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        tile_done = 1; tick(); tile_done = 0;
      end
      send_tile(3'($urandom), 3'($urandom), 3, 0, 0, LANES + 1);
      release_tile(6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
